adder7_share_arb: RTL
=====================

# adder7_share_arb

Round-robin arbiter and sequencer that time-shares one combinational 7-input/4-output approximate adder datapath (exact or factorized k-variant) among NREQ requesters. Each accepted request is registered onto the datapath for one evaluation cycle, and the 4-bit result is captured into a response register. The result is then returned with the requester's ID under a valid/ready handshake. It sits between client logic and a single adder_7-style datapath instance, so several clients can be served by one approximate adder.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, clog2(NREQ), width of requester ID
- CNTW, 16, width of completed-transaction counter
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  7*NREQ  operand bits pi0..pi6 for requester i at [7i+6:7i]
- req_ready  out  NREQ  one-hot grant/accept strobe
- dp_in  out  7  operand bus to datapath (pi0..pi6)
- dp_en  out  1  high during the evaluation cycle
- dp_out  in  4  datapath result (po0..po3), combinational from dp_in
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted by consumer
- rsp_data  out  4  captured datapath result
- rsp_id  out  IDW  index of requester served
- txn_count  out  CNTW  completed responses, wraps modulo 2^CNTW

## Operation
- FSM with states IDLE, EVAL and RESP; exactly one transaction in flight.
- IDLE:
  - Grant the first asserted req_valid, searching upward (with wrap) from ptr.
  - req_ready[g] = 1 combinationally for the granted index only; all other bits are 0.
  - If no req_valid bit is set, req_ready = 0 and the FSM stays in IDLE.
  - On accept: register req_data[g] into dp_in and g into rsp_id, set ptr = (g+1) mod NREQ, go to EVAL.
- EVAL:
  - dp_en = 1 and dp_in holds the operand.
  - At the closing edge: rsp_data <= dp_out, go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_id are held stable.
  - On rsp_valid & rsp_ready: txn_count += 1 (wraps), go to IDLE.
  - req_ready = 0 in this state.
- ptr is a round-robin pointer; its reset value is 0, so requester 0 has top priority after reset.
- dp_in is held after EVAL until the next accept, to avoid datapath toggling.
- Arbitration fairness: a requester holding req_valid continuously is served within NREQ transactions.
- req_valid may drop at any time without having been granted; no request is latched unless req_ready was high.
- NREQ not a power of two: the pointer wraps at NREQ-1 → 0; indices ≥ NREQ are never granted.

## Timing
- Reset (async assert, state cleared immediately):
  - state = IDLE, ptr = 0.
  - dp_in = 0, dp_en = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0.
  - txn_count = 0, req_ready = 0 while rst is high.
- Reset deassertion is taken synchronously by the consumer logic. The first accept is possible in the first cycle after rst falls.
- Cycle-level latency:
  - Accept edge at cycle T.
  - dp_en high during T+1.
  - rsp_valid high from T+2.
  - With rsp_ready tied high, the response handshake completes at the end of T+2.
- Minimum initiation interval is 3 cycles per transaction. There is no overlap: a new accept is not possible in the RESP handshake cycle.
- Backpressure: with rsp_ready low, the block stays in RESP indefinitely with outputs constant, and req_ready stays 0.
- Reset mid-transaction (EVAL or RESP): the transaction is dropped with no response and txn_count is not incremented.
- dp_out is sampled only at the EVAL edge; its value in any other cycle is ignored.
- The datapath combinational delay must fit in one clk period.

## Test plan
- Reset check: assert rst mid-RESP with rsp_data=4'hA → all outputs 0 immediately. After release, req_valid=4'b1000 → req_ready=4'b1000 in the next cycle.
- Single request: req_valid=4'b0010, req_data[13:7]=7'h55, bench datapath returns 4'h9 → dp_en high at T+1 with dp_in=7'h55; rsp_valid at T+2 with rsp_data=4'h9, rsp_id=1; txn_count=1.
- Round-robin fairness: all req_valid=4'b1111 held continuously → grant order 0,1,2,3,0 and txn_count=5 after five handshakes, each exactly 3 cycles apart with rsp_ready=1.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_data and rsp_id are constant, req_ready=0, and dp_out changes are ignored. Release → one handshake only.
- Pointer wrap with NREQ=3: requester 2 then requester 0 requesting → grant 2, then 0 (ptr wraps 2→0); index 3 is never granted.
- Counter wrap with CNTW=4: run 17 transactions → txn_count sequence ends at 1. Compare the rsp_data stream against the bench adder model for random operands.

Source files
------------

// File: rtl/adder7_share_arb.sv
// Round-robin arbiter that time-shares one combinational 7-in/4-out adder datapath
// among NREQ requesters: accept -> one evaluation cycle -> held response with requester ID.
module adder7_share_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [7*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [6:0]        dp_in,
   output logic              dp_en,
   input  logic [3:0]        dp_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [3:0]        rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic [CNTW-1:0]   txn_count
);

   typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_found;
   logic             accept;
   logic [6:0]       dp_in_q;
   logic [3:0]       rsp_data_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [CNTW-1:0]  cnt_q;
   logic [6:0]       req_op [NREQ];

   // Modular index base+off over 0..NREQ-1, so non-power-of-two NREQ wraps correctly.
   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[wrap_idx(ptr_q, k)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_idx(ptr_q, k);
         end
      end
   end

   assign accept = (state_q == S_IDLE) && gnt_found && !rst;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_op[gi]    = req_data[7*gi +: 7];
         assign req_ready[gi] = accept && (gnt_idx == IDW'(gi));
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_EVAL;
               ptr_d   = wrap_idx(gnt_idx, 1);
            end
         end
         S_EVAL:  state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         dp_in_q    <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         // Operand stays on dp_in until the next accept to keep the datapath quiet.
         if (accept) begin
            dp_in_q  <= req_op[gnt_idx];
            rsp_id_q <= gnt_idx;
         end
         if (state_q == S_EVAL) rsp_data_q <= dp_out;
         if (state_q == S_RESP && rsp_ready) cnt_q <= cnt_q + CNTW'(1);
      end
   end

   assign dp_in     = dp_in_q;
   assign dp_en     = (state_q == S_EVAL);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign txn_count = cnt_q;

endmodule
